// File: rtl/l5_ram_banked_if.sv
// ============================================================================
// Module      : l5_ram_banked_if
// Description : Request/response bus for the l5_ram_banked single-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface l5_ram_banked_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    logic            cs;
    logic            we;
    logic            oe;
    logic [AW-1:0]   a;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   di;
    logic [DW-1:0]   dout;
    logic            rvalid;
    logic            ready;

    modport master (
        output cs, we, oe, a, be, di,
        input  dout, rvalid, ready
    );

    modport slave (
        input  cs, we, oe, a, be, di,
        output dout, rvalid, ready
    );
endinterface

`default_nettype wire

// File: rtl/l5_ram_banked.sv
// ============================================================================
// Module      : l5_ram_banked
// Description : Banked single-port RAM with byte enables, registered read and
//               optional post-reset clear engine (macro L5_RAM_CLEAR_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l5_ram_banked #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int BANKS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    l5_ram_banked_if.slave    bus
);
    localparam int AW       = $clog2(DEPTH);
    localparam int c_NB     = DW / 8;
    localparam int c_ROWS   = DEPTH / BANKS;
    localparam int c_BW     = $clog2(BANKS);
    localparam int c_RW     = $clog2(c_ROWS);
    localparam int c_BW_S   = (c_BW > 0) ? c_BW : 1;
    localparam int c_RW_S   = (c_RW > 0) ? c_RW : 1;

    logic [c_BW_S-1:0] w_bank;
    logic [c_BW_S-1:0] r_sel;
    logic [c_RW_S-1:0] w_row;
    logic              w_ready;
    logic              w_acc;
    logic              w_rd;
    logic              r_rvalid;
    logic [BANKS-1:0]  w_en;
    logic [DW-1:0]     w_q [BANKS];

`ifdef L5_RAM_CLEAR_EN
    localparam logic [0:0]        c_ST_CLEAR = 1'b0;
    localparam logic [0:0]        c_ST_RUN   = 1'b1;
    localparam logic [c_RW_S-1:0] c_LAST     = c_RW_S'(c_ROWS - 1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nx;
    logic [c_RW_S-1:0] r_cnt;
    logic [c_RW_S-1:0] w_cnt_nx;
    logic              w_clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            c_ST_CLEAR: begin
                w_cnt_nx = r_cnt + c_RW_S'(1);
                if (r_cnt == c_LAST) begin
                    w_state_nx = c_ST_RUN;
                end
            end
            default: begin
                w_state_nx = c_ST_RUN;
            end
        endcase
    end

    always_comb begin
        w_ready = (r_state == c_ST_RUN);
        w_clr   = (r_state == c_ST_CLEAR) && rst_n;
    end
`else
    logic r_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    assign w_ready = r_ready;
`endif

    // The reset term keeps a request coinciding with a reset edge from landing.
    assign w_acc = bus.cs && w_ready && rst_n;
    assign w_rd  = w_acc && !bus.we;

    generate
        if (BANKS > 1) begin : g_bank_sel
            assign w_bank = bus.a[AW-1 -: c_BW];
        end else begin : g_bank_one
            assign w_bank = '0;
        end

        if (c_RW > 0) begin : g_row_sel
            assign w_row = bus.a[c_RW-1:0];
        end else begin : g_row_one
            assign w_row = '0;
        end

        for (genvar b = 0; b < BANKS; b++) begin : g_bank
            logic [DW-1:0] r_mem [c_ROWS];
            logic [DW-1:0] r_q;

            assign w_en[b] = w_acc && (w_bank == c_BW_S'(b));
            assign w_q[b]  = r_q;

            always_ff @(posedge clk) begin
`ifdef L5_RAM_CLEAR_EN
                if (w_clr) begin
                    r_mem[r_cnt] <= '0;
                end else
`endif
                if (w_en[b] && bus.we) begin
                    for (int i = 0; i < c_NB; i++) begin
                        if (bus.be[i]) begin
                            r_mem[w_row][8*i +: 8] <= bus.di[8*i +: 8];
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (w_en[b] && !bus.we) begin
                    r_q <= r_mem[w_row];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_sel    <= '0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_sel <= w_bank;
            end
        end
    end

    assign bus.dout   = bus.oe ? w_q[r_sel] : '0;
    assign bus.rvalid = r_rvalid;
    assign bus.ready  = w_ready;

endmodule

`default_nettype wire

// File: doc/l5_ram_banked.md
# l5_ram_banked

Parametrised single-port synchronous RAM that replaces the fixed 256x32 array of 64x8 tiles with a configurable width, depth and bank count. It adds per-byte write enables, a registered read port with a valid strobe, and a ready flag. Behind the ready flag, a hardware clear engine zeroes the array after reset. It is the general-purpose data/instruction store for the L5 datapath.

## Interface
Parameters:
- DW, 32, data width in bits; multiple of 8
- DEPTH, 256, words; power of two, at least BANKS
- BANKS, 4, number of row banks; power of two, at most DEPTH
- AW, $clog2(DEPTH), derived address width (localparam, not overridden)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cs  in  1  request strobe; accepted when cs && ready
- we  in  1  1 = write, 0 = read (sampled with cs)
- oe  in  1  output enable; rdata forced to 0 while low
- a  in  AW  word address; a[AW-1 -: log2(BANKS)] selects the bank, the rest selects the row
- be  in  DW/8  byte write enables, bit i covers di[8i+7:8i]
- di  in  DW  write data
- dout  out  DW  read data (registered)
- rvalid  out  1  one-cycle pulse, dout carries the read accepted on the previous cycle
- ready  out  1  block accepts requests

## Operation
- Storage is BANKS banks of DEPTH/BANKS rows x DW bits. Only the selected bank is enabled per access.
- States are CLEAR and RUN.
- Reset puts the block in CLEAR with row counter 0.
  - Each CLEAR cycle writes 0 to the row given by the counter, in all banks at once.
  - The counter increments each cycle. After row DEPTH/BANKS-1 the block enters RUN on the next cycle.
  - CLEAR lasts exactly DEPTH/BANKS cycles, and ready=0 throughout.
- RUN: ready=1.
  - Write (cs=1, we=1) updates only the bytes with be[i]=1; other bytes keep their value.
  - be=0 with we=1 is a legal no-op, and rvalid stays 0.
  - Read (cs=1, we=0) registers the word into dout and pulses rvalid the next cycle.
- Requests while ready=0 are ignored: no write, no rvalid.
- dout holds the last read word until the next read completes. It is not updated by writes.
- oe gates only the output: dout reads 0 while oe=0, and the internal read register is unaffected.
- Back-to-back operations are allowed every cycle with no bubble.
- Read-after-write to the same address on the following cycle returns the new data.
- Reset asserted mid-operation, including mid-CLEAR, restarts CLEAR from row 0.
  - An in-flight read is dropped and no rvalid is issued.

## Timing
- Reset values: dout=0, rvalid=0, ready=0. In CLEAR builds ready stays 0 until CLEAR ends.
- Read latency is 1 cycle: request on edge N, dout/rvalid valid after edge N+1, rvalid high for exactly one cycle per read.
- A write takes effect at the accepting edge and is visible to a read accepted on the next edge.
- ready rises on the first cycle after the last clear write. A request in that same cycle is accepted.
- Default config: ready=0 for cycles 1..64 after rst_n rises, and ready=1 from cycle 65.

## Configuration
- L5_RAM_CLEAR_EN defined: the CLEAR state and counter are built as described, and the array reads 0 after every reset.
- L5_RAM_CLEAR_EN undefined: the CLEAR logic is removed and array contents after reset are undefined.
  - ready=0 only while rst_n=0, and ready=1 on the first cycle after rst_n rises.
  - Latencies are otherwise identical.

## Test plan
- Clear (macro defined), default params: release reset, count cycles -> ready rises after exactly 64 cycles; reading all 256 addresses returns 0x00000000, each with a single rvalid pulse.
- Byte enables: write 0xAABBCCDD to 0x45 with be=1111, then 0x11223344 with be=0101 -> read of 0x45 returns 0xAA22CC44.
- Bank decode: write 0x000000A0/0x000000A1/0x000000A2/0x000000A3 to 0x05/0x45/0x85/0xC5 -> each reads back its own value, with no aliasing between banks.
- Pipelining and oe: alternate write/read to 0x10 every cycle with oe toggling -> reads return the just-written data one cycle later; dout=0 whenever oe=0, while rvalid timing is unchanged.
- Reset mid-CLEAR: assert rst_n=0 at clear cycle 30, release -> ready stays 0 for a full 64 cycles; a request with ready=0 writes nothing and gives no rvalid.
- Parametrisation: DW=64, DEPTH=1024, BANKS=8 -> clear lasts 128 cycles; write/read at 0x3FF with be=0x0F returns only the low 32 bits updated.
